// File: rtl/cpu_mem_responder_pkg.sv
// cpu_mem_responder_pkg
// Holds what the responder files share: the default address and data widths,
// the LOAD/START/RUN state encoding, and the saturating store counter helper.
package cpu_mem_responder_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    // These constants are also what the fsm_state debug output carries.
    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [7:0] STORE_COUNT_MAX = 8'd255;

    // Adds one to the store count, but holds at 255 instead of wrapping to 0.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == STORE_COUNT_MAX) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/cpu_mem_responder_if.sv
// cpu_mem_responder_if
// Carries every signal between the responder and the CPU/host side.
//   CPU instruction port : i_addr -> i_datain
//   CPU data port        : d_addr, d_dataout, d_we -> d_datain
//   Host load port       : host_valid/host_ready, host_sel, host_addr, host_data
//   Host control         : host_go, host_stop
//   CPU control          : cpu_enable, cpu_start, store_count
//   Debug                : fsm_state, which is the current responder state
//
// Handshake on the host load port: a word is transferred on any rising edge
// where host_valid and host_ready are both 1. host_ready does not depend on
// host_valid. The host holds its word and address steady while host_valid is
// 1 and host_ready is 0.
//
// Modports: slave is the responder side; master is the CPU/host side.
interface cpu_mem_responder_if
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] i_addr;
    logic [DATA_W-1:0] i_datain;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_dataout;
    logic              d_we;
    logic [DATA_W-1:0] d_datain;
    logic              host_valid;
    logic              host_ready;
    logic              host_sel;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              host_go;
    logic              host_stop;
    logic              cpu_enable;
    logic              cpu_start;
    logic [7:0]        store_count;
    logic [1:0]        fsm_state;

    modport slave (
        input  i_addr, d_addr, d_dataout, d_we,
        input  host_valid, host_sel, host_addr, host_data, host_go, host_stop,
        output i_datain, d_datain, host_ready,
        output cpu_enable, cpu_start, store_count, fsm_state
    );

    modport master (
        output i_addr, d_addr, d_dataout, d_we,
        output host_valid, host_sel, host_addr, host_data, host_go, host_stop,
        input  i_datain, d_datain, host_ready,
        input  cpu_enable, cpu_start, store_count, fsm_state
    );

endinterface

// File: rtl/cpu_mem_responder_mem_array.sv
// mem_array
// A 2^ADDR_W x DATA_W memory with one synchronous write port and one
// combinational read port. A read of an address in the same cycle that the
// address is written returns the old word. The new word is visible from the
// next cycle. The contents are never reset.
//   clock : write clock, rising edge
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : read data, zero latency
module mem_array
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_mem_responder.sv
// cpu_mem_responder
// Provides the instruction memory (IMEM) and data memory (DMEM) for a CPU,
// and the load/run sequencing around them.
//   - LOAD : the host fills IMEM or DMEM, and the CPU is held disabled.
//   - START: lasts one cycle. The CPU gets its start pulse here, and
//            store_count is cleared.
//   - RUN  : the CPU executes. Its stores go to DMEM and are counted.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-low. Forces LOAD and blocks all writes.
//   bus   : cpu_mem_responder_if.slave, which carries the CPU, host and
//           debug signals
module cpu_mem_responder
    import cpu_mem_responder_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clock,
    input  logic                  reset,
    cpu_mem_responder_if.slave    bus
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [7:0]        store_count;

    logic              host_accept;
    logic              cpu_store;
    logic              imem_we;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0] dmem_wdata;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // In LOAD, host_go wins over host_stop. In START and RUN, only host_stop
    // has any effect.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD:  if (bus.host_go) state_nxt = ST_START;
            ST_START: state_nxt = bus.host_stop ? ST_LOAD : ST_RUN;
            ST_RUN:   if (bus.host_stop) state_nxt = ST_LOAD;
            default:  state_nxt = ST_LOAD;
        endcase
    end

    // -------------------------------------------------------- write gating
    // Each memory has one write port. The host owns that port in LOAD and the
    // CPU owns it in RUN, so the two sources can never collide. Gating with
    // reset keeps the memories untouched while reset is held low.
    assign host_accept = reset && (state == ST_LOAD) && bus.host_valid;
    assign cpu_store   = reset && (state == ST_RUN) && bus.d_we;

    assign imem_we    = host_accept && !bus.host_sel;
    assign dmem_we    = (host_accept && bus.host_sel) || cpu_store;
    assign dmem_waddr = cpu_store ? bus.d_addr    : bus.host_addr;
    assign dmem_wdata = cpu_store ? bus.d_dataout : bus.host_data;

    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_imem (
        .clock (clock),
        .we    (imem_we),
        .waddr (bus.host_addr),
        .wdata (bus.host_data),
        .raddr (bus.i_addr),
        .rdata (bus.i_datain)
    );

    mem_array #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_dmem (
        .clock (clock),
        .we    (dmem_we),
        .waddr (dmem_waddr),
        .wdata (dmem_wdata),
        .raddr (bus.d_addr),
        .rdata (bus.d_datain)
    );

    // ------------------------------------------------------- store counter
    // The count keeps its value through LOAD after a stop, so the host can
    // read the result of the last run. It is cleared only when a new run
    // begins.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            store_count <= 8'd0;
        end else if (state == ST_START) begin
            store_count <= 8'd0;
        end else if (cpu_store) begin
            store_count <= sat_inc(store_count);
        end
    end

    // ------------------------------------------------------------ outputs
    assign bus.host_ready  = (state == ST_LOAD);
    assign bus.cpu_enable  = (state == ST_START) || (state == ST_RUN);
    assign bus.cpu_start   = (state == ST_START);
    assign bus.store_count = store_count;
    assign bus.fsm_state   = state;

endmodule

// File: doc/cpu_mem_responder.md
CPU_MEM_RESPONDER -- requirements
Module: cpu_mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width of both memory spaces.
REQ-002 SHALL have parameter DATA_W, default 16, word width of both memory spaces.
REQ-003 SHALL have port clock  in  1  system clock, rising edge active.
REQ-004 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port i_addr  in  ADDR_W  CPU instruction fetch address.
REQ-006 SHALL have port i_datain  out  DATA_W  instruction word to CPU.
REQ-007 SHALL have port d_addr  in  ADDR_W  CPU data address.
REQ-008 SHALL have port d_dataout  in  DATA_W  CPU store data.
REQ-009 SHALL have port d_we  in  1  CPU store strobe.
REQ-010 SHALL have port d_datain  out  DATA_W  load data to CPU.
REQ-011 SHALL have port host_valid  in  1  host load word offered.
REQ-012 SHALL have port host_ready  out  1  host load word accepted this cycle.
REQ-013 SHALL have port host_sel  in  1  0 = instruction memory, 1 = data memory.
REQ-014 SHALL have port host_addr  in  ADDR_W  host load address.
REQ-015 SHALL have port host_data  in  DATA_W  host load word.
REQ-016 SHALL have port host_go  in  1  request CPU run.
REQ-017 SHALL have port host_stop  in  1  request CPU halt and return to load mode.
REQ-018 SHALL have port cpu_enable  out  1  drives CPU enable.
REQ-019 SHALL have port cpu_start  out  1  one-cycle start pulse to CPU.
REQ-020 SHALL have port store_count  out  8  number of CPU stores honoured in the current run.

Function
REQ-021 SHALL contain two 2^ADDR_W x DATA_W arrays: IMEM and DMEM.
REQ-022 SHALL drive i_datain = IMEM[i_addr] and d_datain = DMEM[d_addr] combinationally, with zero-cycle read latency.
REQ-023 SHALL have FSM states LOAD, START and RUN; state after reset is LOAD.
REQ-024 In LOAD: host_ready=1, cpu_enable=0, cpu_start=0; on host_valid=1 at a rising edge, SHALL write host_data to IMEM or DMEM at host_addr per host_sel.
REQ-025 In LOAD with host_go=1: SHALL go to START next edge; a host_valid in the same cycle SHALL still be written.
REQ-026 In START, lasting exactly 1 cycle: cpu_start=1, cpu_enable=1, host_ready=0; store_count SHALL clear to 0; next state is RUN.
REQ-027 In RUN: cpu_enable=1, cpu_start=0, host_ready=0; host_valid SHALL be ignored; host_go SHALL be ignored.
REQ-028 In RUN with d_we=1 at a rising edge: SHALL write d_dataout to DMEM[d_addr]; store_count SHALL increment and saturate at 255.
REQ-029 d_we in LOAD or START SHALL be ignored, with no write and no count change.
REQ-030 host_stop=1 in START or RUN SHALL go to LOAD next edge; a d_we in that same RUN cycle SHALL still be honoured.
REQ-031 host_stop in LOAD SHALL have no effect; host_go and host_stop together in LOAD SHALL go to START (go wins).
REQ-032 A read of an address in the same cycle as its write SHALL return the old word; from the next cycle it SHALL return the new word.
REQ-033 IMEM SHALL never be written by the CPU port.
REQ-034 Address arithmetic SHALL be ADDR_W-bit with no bounds check; every address is valid.

Reset
REQ-035 reset=0 SHALL immediately force LOAD, cpu_enable=0, cpu_start=0, host_ready=1 and store_count=0, including mid-run.
REQ-036 Memory contents SHALL NOT be cleared by reset.
REQ-037 Writes SHALL be suppressed while reset=0.

Structure
REQ-038 Shared package SHALL hold the state encoding (LOAD, START, RUN) and the ADDR_W and DATA_W defaults.
REQ-039 SHALL instantiate sub-module mem_array twice (IMEM, DMEM); mem_array is a single-write-port, async-read, 2^ADDR_W x DATA_W array.

Verification
REQ-040 Load test: host writes IMEM[0x05]=0x1234 and DMEM[0x10]=0xBEEF in LOAD -> i_addr=0x05 gives i_datain=0x1234; d_addr=0x10 gives d_datain=0xBEEF.
REQ-041 Start test: host_go pulse -> cpu_start high exactly 1 cycle, cpu_enable high from START onward, host_ready low, store_count=0.
REQ-042 Store test: in RUN, d_we=1, d_addr=0x20, d_dataout=0x00AA -> DMEM[0x20]=0x00AA next cycle, store_count=1; a same-cycle read of 0x20 returns the old value.
REQ-043 Blocked-write test: d_we=1 in LOAD, and host_valid=1 in RUN -> memory and store_count unchanged.
REQ-044 Saturation and stop test: 300 stores in RUN -> store_count=255; host_stop -> LOAD next cycle with cpu_enable=0.
REQ-045 Reset mid-run test: assert reset in RUN -> immediate LOAD with outputs at reset values; DMEM[0x20] still reads 0x00AA.
